// File: rtl/srrc_resp_capture.sv
// srrc_resp_capture: threshold-triggered impulse-response capture with readout.
// Optional peak tracker is built when SRRC_CAPTURE_PEAK_EN is defined.
module srrc_resp_capture #(
    parameter int DATA_W = 18,
    parameter int LEN    = 32,
    parameter int IDX_W  = $clog2(LEN)
) (
    input  logic                     sys_clk,
    input  logic                     reset,
    input  logic                     sam_clk_en,
    input  logic signed [DATA_W-1:0] din,
    input  logic        [DATA_W-1:0] thresh,
    input  logic                     arm,
    output logic                     busy,
    output logic                     triggered,
    output logic                     done,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic signed [DATA_W-1:0] rd_data,
    output logic                     rd_last,
    output logic signed [DATA_W-1:0] peak_val,
    output logic        [IDX_W-1:0]  peak_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_READOUT
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(LEN - 1);

    state_t state;
    state_t state_nx;

    logic signed [DATA_W-1:0] mem [LEN];
    logic        [IDX_W-1:0]  wr_cnt;
    logic        [IDX_W-1:0]  rd_ptr;
    logic        [DATA_W-1:0] mag;
    logic                     trig_hit;
    logic                     cap_wr;
    logic                     rd_hs;
    logic                     rd_end;
    logic                     done_q;

    // Most negative input wraps to 2^(DATA_W-1), which is exact as unsigned.
    assign mag = din[DATA_W-1] ? ((~din) + DATA_W'(1)) : din;

    assign trig_hit = (state == S_ARMED) && sam_clk_en && (mag >= thresh);
    assign cap_wr   = (state == S_CAPTURE) && sam_clk_en;
    assign rd_hs    = (state == S_READOUT) && rd_ready;
    assign rd_end   = rd_hs && (rd_ptr == LAST);

    assign busy      = (state != S_IDLE);
    assign triggered = (state == S_CAPTURE) || (state == S_READOUT);
    assign rd_valid  = (state == S_READOUT);
    assign rd_last   = rd_valid && (rd_ptr == LAST);
    assign rd_data   = rd_valid ? mem[rd_ptr] : '0;
    assign done      = done_q;

    // State register and one-cycle done pulse after the final handshake.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state  <= S_IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= rd_end;
        end
    end

    // Next-state logic; an arm coinciding with done is dropped.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:    if (arm && !done_q) state_nx = S_ARMED;
            S_ARMED:   if (trig_hit) state_nx = S_CAPTURE;
            S_CAPTURE: if (cap_wr && (wr_cnt == LAST)) state_nx = S_READOUT;
            S_READOUT: if (rd_end) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Write count and read pointer; the pointer rewinds outside readout.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            wr_cnt <= '0;
            rd_ptr <= '0;
        end else begin
            if (trig_hit) begin
                wr_cnt <= IDX_W'(1);
            end else if (cap_wr) begin
                wr_cnt <= wr_cnt + IDX_W'(1);
            end
            if (state != S_READOUT) begin
                rd_ptr <= '0;
            end else if (rd_hs) begin
                rd_ptr <= rd_ptr + IDX_W'(1);
            end
        end
    end

    // Capture buffer; contents are meaningless after reset.
    always_ff @(posedge sys_clk) begin
        if (trig_hit) begin
            mem[0] <= din;
        end else if (cap_wr) begin
            mem[wr_cnt] <= din;
        end
    end

`ifdef SRRC_CAPTURE_PEAK_EN
    logic [DATA_W-1:0] pk_mag;

    // Peak tracker: trigger seeds it, strictly larger magnitudes replace it.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            peak_val <= '0;
            peak_idx <= '0;
            pk_mag   <= '0;
        end else if (trig_hit) begin
            peak_val <= din;
            peak_idx <= '0;
            pk_mag   <= mag;
        end else if (cap_wr && (mag > pk_mag)) begin
            peak_val <= din;
            peak_idx <= wr_cnt;
            pk_mag   <= mag;
        end
    end
`else
    assign peak_val = '0;
    assign peak_idx = '0;
`endif

endmodule

// File: doc/srrc_resp_capture.md
# srrc_resp_capture

Hardware impulse-response capture unit for the SRRC filter chain. It monitors a filter output sample stream and triggers when the sample magnitude reaches a threshold. On trigger it stores a fixed-length window of samples in an internal buffer, then streams the window out over a valid/ready interface. It sits at the output end of a filter under test (TX, RX or halfband) and provides on-chip capture of the response that the impulse stimulus path excites.

## Interface
Parameters:
- `DATA_W`, 18: sample width, signed two's complement.
- `LEN`, 32: capture window length in samples; a power of two, 4..256.
- `IDX_W`, log2(`LEN`): width of the index outputs.

Ports:
- `sys_clk`  in  1: single system clock. All logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `sam_clk_en`  in  1: sample-rate enable. `din` is valid only when this is high.
- `din`  in  `DATA_W`: filter output sample, signed.
- `thresh`  in  `DATA_W`: trigger threshold, unsigned magnitude. Static while armed.
- `arm`  in  1: one-cycle pulse that starts a capture.
- `busy`  out  1: high in ARMED, CAPTURE and READOUT.
- `triggered`  out  1: high in CAPTURE and READOUT.
- `done`  out  1: one-cycle pulse after the final readout handshake.
- `rd_valid`  out  1: a readout word is available.
- `rd_ready`  in  1: the consumer accepts the word.
- `rd_data`  out  `DATA_W`: readout sample, signed.
- `rd_last`  out  1: the current word is sample `LEN`-1.
- `peak_val`  out  `DATA_W`: captured sample with the largest magnitude, signed.
- `peak_idx`  out  `IDX_W`: window index of `peak_val`.

## Operation
State machine: IDLE, ARMED, CAPTURE, READOUT.

- **IDLE**
  - `arm`=1 moves to ARMED on the next cycle.
- **ARMED**
  - `arm` is ignored.
  - Magnitude `mag` = |`din`|, computed as `DATA_W`-bit unsigned. The most negative input gives 2^(`DATA_W`-1) with no saturation.
  - On `sam_clk_en` with `mag` >= `thresh`: write `din` to buffer index 0, set write count to 1, go to CAPTURE.
  - `thresh`=0 triggers on the first enabled sample.
- **CAPTURE**
  - Each `sam_clk_en` writes `din` at the write count, then increments the count.
  - Samples without the enable are not stored.
  - The write to index `LEN`-1 moves to READOUT on the next cycle.
- **READOUT**
  - Read pointer starts at 0.
  - `rd_data` = buffer[pointer]. `rd_last` = (pointer == `LEN`-1).
  - Handshake occurs when `rd_valid` && `rd_ready`. The pointer advances and the next word is presented the following cycle, so back-to-back transfers have no bubbles.
  - While `rd_ready`=0, `rd_valid`, `rd_data` and `rd_last` hold steady.
  - The handshake on the last word moves to IDLE and pulses `done` on the next cycle.
  - `din`, `sam_clk_en` and `arm` are ignored.
- **Peak tracking (CAPTURE and trigger sample)**
  - Tracking applies to the trigger sample and every sample written in CAPTURE.
  - Update `peak_val`/`peak_idx` only when `mag` is strictly greater than the stored peak magnitude, so ties keep the earliest index.
  - The trigger sample initialises the peak.
  - Peak outputs are stable from entry to READOUT until the next trigger.

## Timing
- Reset values:
  - State: IDLE.
  - Outputs: `busy`=0, `triggered`=0, `done`=0, `rd_valid`=0, `rd_last`=0, `rd_data`=0, `peak_val`=0, `peak_idx`=0.
- Reset mid-operation, in any state: the capture is discarded and the block returns to IDLE on the next edge. Buffer contents are don't-care.
- `arm` to `busy` high: 1 cycle.
- Trigger sample enable to `triggered` high: 1 cycle.
- Final capture enable to `rd_valid` high: at most 2 cycles. `rd_valid` asserts together with valid `rd_data` for index 0.
- Minimum readout duration is `LEN` cycles with `rd_ready` tied high.
- `done` is high for exactly 1 cycle. `busy` falls in the same cycle that `done` rises.
- If `arm` arrives in the same cycle as `done`, it is ignored. A new arm is accepted from the cycle after `done`.

## Configuration
- `SRRC_CAPTURE_PEAK_EN`
  - Defined: peak tracking is as described above.
  - Undefined: no magnitude comparator or peak registers are built, and `peak_val` and `peak_idx` are constant 0.
- Trigger and capture behaviour is identical in both cases.

## Test plan
- **Impulse capture**: `thresh`=1000. Apply `din`=0 for 20 enables, then +32768 for 1 enable, then 0. With `rd_ready`=1, expect 32 words: word 0 = 32768, words 1..31 = 0. Expect `rd_last` only on word 31, `peak_val`=32768, `peak_idx`=0, and one `done` pulse.
- **Ramp and peak tie**: trigger on `din`=-4096, then feed -4096, +5000, -5000, ... Expect `peak_val`=+5000 at `peak_idx`=2, because the equal-magnitude tie keeps the earlier index.
- **Backpressure**: toggle `rd_ready` 1/0 per cycle. Expect 32 distinct words in order, `rd_data` stable while stalled, and `done` after word 31.
- **Most negative input**: `din`=-131072 with `thresh`=131072. Expect a trigger, and `rd_data` word 0 = -131072.
- **Reset in CAPTURE**: assert `reset` after 10 captured samples. Expect IDLE with `busy`=0 and `rd_valid`=0. A re-arm captures a fresh window.
- **Sparse enables**: pulse `sam_clk_en` every 4th cycle. Expect only enabled samples to be stored, and `arm` ignored while in ARMED.
